clk_div_gen: RTL
================

# clk_div_gen

Parametrised multi-channel clock-enable generator; successor to the fixed dual-DCM clock tree. It runs on the DCM-derived bus clock and produces CHANNELS independent divided clock-enable strobes and 50 %-duty divided level outputs with runtime-programmable ratios. It gates all outputs on a qualified DCM lock and re-aligns every channel synchronously after lock recovery or reconfiguration. Consumers such as the serialiser, trigger and TDC logic use the strobes instead of extra BUFG/DCM outputs.

## Interface
- CHANNELS, 4, number of independent divider channels (1..16)
- DIV_WIDTH, 8, width of per-channel divide and phase fields
- LOCK_WAIT, 256, consecutive synchronised-lock cycles required before outputs enable (≥2)
- BUS_CLK  in  1  sole clock, all logic rising-edge
- BUS_RST  in  1  reset; one clock, synchronous active-high reset
- LOCKED_IN  in  1  DCM LOCKED, asynchronous; 2-FF synchronised internally
- CONF_LOAD  in  1  single-cycle pulse; captures DIV/PHASE into shadow registers
- DIV  in  CHANNELS*DIV_WIDTH  channel i field [i*DIV_WIDTH +: DIV_WIDTH]; period P_i = DIV_i+1 cycles
- PHASE  in  CHANNELS*DIV_WIDTH  per-channel start offset (present only with CLK_DIV_GEN_PHASE_EN)
- CLK_EN  out  CHANNELS  one-cycle strobe per period
- CLK_DIV  out  CHANNELS  divided level output
- READY  out  1  high in RUN
- LOCK_LOST_CNT  out  8  saturating count of lock losses seen in RUN

## Operation
- States: WAIT_LOCK, ALIGN, RUN. Reset → WAIT_LOCK.
- WAIT_LOCK: lock counter increments while synced lock=1, clears to 0 when it is 0. Reaching LOCK_WAIT → ALIGN.
- ALIGN, one cycle: every channel counter is loaded with its start value: PHASE_i, or 0 when PHASE_i > DIV_i or the macro is absent. Next state is RUN.
- RUN: each counter counts up and wraps from DIV_i to 0.
  - CLK_EN[i] = RUN && cnt_i==0.
  - CLK_DIV[i] = RUN && cnt_i < (P_i+1)>>1.
  - P=1: CLK_EN and CLK_DIV are constantly high. P=2: both toggle every cycle. Odd P: high phase is the longer one.
- Lock loss in RUN (synced lock=0): go to WAIT_LOCK next cycle, lock counter=0, LOCK_LOST_CNT+1 (saturates at 255).
- CONF_LOAD:
  - Shadows capture DIV/PHASE in every state.
  - In RUN: go to ALIGN next cycle.
  - In WAIT_LOCK/ALIGN: no state change. New values apply at the next ALIGN.
- CONF_LOAD coinciding with lock loss: shadows are loaded, lock loss wins, and the next state is WAIT_LOCK.
- Counters compare only against shadows, never against live DIV.

## Timing
- Reset values: state=WAIT_LOCK, shadows=0 (P=1), counters=0, lock counter=0. Outputs: CLK_EN=0, CLK_DIV=0, READY=0, LOCK_LOST_CNT=0.
- BUS_RST mid-operation: all of the above apply on the next edge. The synchroniser flops also clear.
- Outputs are decoded from registered state/counters only; there is no combinational input-to-output path.
- LOCKED_IN rising to READY rising: 2 sync cycles + LOCK_WAIT + 1 (ALIGN) cycles.
- First CLK_EN after ALIGN, channel with start value s: appears (P−s) mod P cycles after READY rises. For s=0 it is the first RUN cycle.
- CONF_LOAD at cycle t in RUN: READY=0 and outputs=0 at t+2 (ALIGN). RUN resumes at t+3 with new ratios.
- LOCKED_IN fall: outputs drop 3 cycles later (2 sync + state register).

## Configuration
- CLK_DIV_GEN_PHASE_EN defined:
  - PHASE port and phase shadows exist.
  - ALIGN loads PHASE_i (0 if PHASE_i > DIV_i).
- CLK_DIV_GEN_PHASE_EN undefined:
  - No PHASE port and no phase shadows.
  - All channels start at 0 and are edge-aligned.

## Structure
- Package clk_div_gen_pkg holds:
  - state enum (WAIT_LOCK, ALIGN, RUN)
  - LOCK_LOST_CNT width constant (8)
  - function for the half-period threshold (P+1)>>1
- Sub-module clk_div_chan, instantiated CHANNELS times. Per instance:
  - one shadow DIV/PHASE pair, one counter, CLK_EN/CLK_DIV decode
  - inputs: load, align, run
- Top level holds: synchroniser, lock counter, FSM, LOCK_LOST_CNT.

## Test plan
- Reset, LOCKED_IN=1, LOCK_WAIT=16, DIV={0,1,2,9}, CONF_LOAD pulse → READY rises at cycle 19 after lock. CLK_EN periods are 1,2,3,10 cycles. CLK_DIV high/low is 1/0, 1/1, 2/1, 5/5.
- LOCKED_IN glitch low for 1 cycle during WAIT_LOCK at count 10 → lock counter restarts. READY is delayed by 11 cycles relative to the clean case.
- LOCKED_IN drop in RUN, three times → outputs are 0 three cycles after each drop and LOCK_LOST_CNT=3. Realignment occurs after each relock.
- CONF_LOAD in RUN changing DIV[0] 3→5 → ALIGN at t+2. From t+3, channel 0 CLK_EN period is 6 and all channels are re-aligned.
- With CLK_DIV_GEN_PHASE_EN: DIV=7, PHASE={0,2,4,9} → CLK_EN for channels 0/1/2/3 lands 0/6/4/0 cycles after READY (PHASE 9 is clamped to 0).
- BUS_RST asserted mid-RUN alongside CONF_LOAD → next cycle all outputs are 0, state is WAIT_LOCK and shadows are 0. The CONF_LOAD is ignored.

Source files
------------

// File: rtl/clk_div_gen_pkg.sv
// Shared state encoding, widths and the half-period helper for clk_div_gen.
package clk_div_gen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    ALIGN     = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam int unsigned LOST_CNT_W = 8;
  localparam int unsigned HALF_W     = 33;

  // High-phase length for period P = div+1; odd periods give the extra cycle to the high phase.
  function automatic logic [HALF_W-1:0] calc_half_thresh(input logic [31:0] div);
    calc_half_thresh = ({1'b0, div} + 33'd2) >> 1'b1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: shadowed ratio (and phase with CLK_DIV_GEN_PHASE_EN), counter and strobe decode.
module clk_div_chan
  import clk_div_gen_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 align,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [DIV_WIDTH-1:0] phase,
`endif
  output logic                 clk_en,
  output logic                 clk_div
);

  logic [DIV_WIDTH-1:0] div_sh_r;
  logic [DIV_WIDTH-1:0] cnt_r;
  logic [DIV_WIDTH-1:0] start_s;
  logic [HALF_W-1:0]    half_s;

`ifdef CLK_DIV_GEN_PHASE_EN
  logic [DIV_WIDTH-1:0] phase_sh_r;

  // Shadow capture of ratio and phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_sh_r   <= '0;
      phase_sh_r <= '0;
    end else if (load) begin
      div_sh_r   <= div;
      phase_sh_r <= phase;
    end else begin
      div_sh_r   <= div_sh_r;
      phase_sh_r <= phase_sh_r;
    end
  end

  // An out-of-range phase falls back to edge alignment.
  always_comb begin
    start_s = (phase_sh_r > div_sh_r) ? '0 : phase_sh_r;
  end
`else
  // Shadow capture of ratio.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_sh_r <= '0;
    end else if (load) begin
      div_sh_r <= div;
    end else begin
      div_sh_r <= div_sh_r;
    end
  end

  assign start_s = '0;
`endif

  // Period counter: preset during alignment, wraps at the shadowed ratio while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (align) begin
      cnt_r <= start_s;
    end else if (run) begin
      cnt_r <= (cnt_r >= div_sh_r) ? '0 : cnt_r + DIV_WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Strobe and level decode from registered counter only.
  always_comb begin
    half_s  = calc_half_thresh(32'(div_sh_r));
    clk_en  = run && (cnt_r == '0);
    clk_div = run && (HALF_W'(cnt_r) < half_s);
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock-enable generator gated on a qualified DCM lock.
// Optional per-channel start phase: define CLK_DIV_GEN_PHASE_EN.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DIV_WIDTH = 8,
  parameter int LOCK_WAIT = 256
) (
  input  logic                          BUS_CLK,
  input  logic                          BUS_RST,
  input  logic                          LOCKED_IN,
  input  logic                          CONF_LOAD,
  input  logic [CHANNELS*DIV_WIDTH-1:0] DIV,
`ifdef CLK_DIV_GEN_PHASE_EN
  input  logic [CHANNELS*DIV_WIDTH-1:0] PHASE,
`endif
  output logic [CHANNELS-1:0]           CLK_EN,
  output logic [CHANNELS-1:0]           CLK_DIV,
  output logic                          READY,
  output logic [LOST_CNT_W-1:0]         LOCK_LOST_CNT
);

  localparam int LC_W = $clog2(LOCK_WAIT + 1);
  localparam logic [LC_W-1:0] LOCK_LAST = LC_W'(LOCK_WAIT - 1);

  state_e                state_r;
  state_e                state_nx_s;
  logic                  lock_meta_r;
  logic                  lock_sync_r;
  logic                  conf_run_r;
  logic [LC_W-1:0]       lock_cnt_r;
  logic [LOST_CNT_W-1:0] lost_cnt_r;
  logic                  align_s;
  logic                  run_s;

  // Two-flop synchroniser for the asynchronous DCM lock.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lock_meta_r <= 1'b0;
      lock_sync_r <= 1'b0;
    end else begin
      lock_meta_r <= LOCKED_IN;
      lock_sync_r <= lock_meta_r;
    end
  end

  // Reconfiguration seen in RUN re-aligns one cycle later, after the shadows settle.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      conf_run_r <= 1'b0;
    end else begin
      conf_run_r <= CONF_LOAD && (state_r == RUN);
    end
  end

  // Consecutive-lock counter, only live while waiting for lock.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lock_cnt_r <= '0;
    end else if ((state_r == WAIT_LOCK) && lock_sync_r) begin
      lock_cnt_r <= lock_cnt_r + LC_W'(1);
    end else begin
      lock_cnt_r <= '0;
    end
  end

  // State register.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_r <= WAIT_LOCK;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; lock loss outranks reconfiguration.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      WAIT_LOCK: begin
        if (lock_sync_r && (lock_cnt_r == LOCK_LAST)) begin
          state_nx_s = ALIGN;
        end else begin
          state_nx_s = WAIT_LOCK;
        end
      end
      ALIGN: state_nx_s = RUN;
      RUN: begin
        if (!lock_sync_r) begin
          state_nx_s = WAIT_LOCK;
        end else if (conf_run_r) begin
          state_nx_s = ALIGN;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: state_nx_s = WAIT_LOCK;
    endcase
  end

  // Saturating count of lock losses observed while running.
  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      lost_cnt_r <= '0;
    end else if ((state_r == RUN) && !lock_sync_r && (lost_cnt_r != {LOST_CNT_W{1'b1}})) begin
      lost_cnt_r <= lost_cnt_r + LOST_CNT_W'(1);
    end else begin
      lost_cnt_r <= lost_cnt_r;
    end
  end

  assign align_s       = (state_r == ALIGN);
  assign run_s         = (state_r == RUN);
  assign READY         = run_s;
  assign LOCK_LOST_CNT = lost_cnt_r;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clk_div_chan #(
      .DIV_WIDTH(DIV_WIDTH)
    ) u_chan (
      .clk    (BUS_CLK),
      .rst    (BUS_RST),
      .load   (CONF_LOAD),
      .align  (align_s),
      .run    (run_s),
      .div    (DIV[i*DIV_WIDTH +: DIV_WIDTH]),
`ifdef CLK_DIV_GEN_PHASE_EN
      .phase  (PHASE[i*DIV_WIDTH +: DIV_WIDTH]),
`endif
      .clk_en (CLK_EN[i]),
      .clk_div(CLK_DIV[i])
    );
  end

endmodule
